mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- M-stage load/store unit: the consumer side of the EX/MEM pipeline register.
- Takes the registered M_op/M_func3/M_rd/M_aluOut/M_rs2_data and runs one data-memory transaction per load/store over a req/ready + rvalid handshake.
- Asserts DM_stall back to the pipeline registers while the transaction is outstanding.
- Presents the aligned, sign/zero-extended load result to the MEM/WB register.

Parameters:
- LOAD_OP, 5'b00000, M_op value for loads (instr[6:2])
- STORE_OP, 5'b01000, M_op value for stores (instr[6:2])

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- IM_stall  in  1  instruction-memory stall; pipeline frozen while high
- M_op  in  5  M-stage opcode[6:2]
- M_func3  in  3  M-stage funct3
- M_rd  in  5  M-stage destination register
- M_aluOut  in  32  effective address for loads/stores
- M_rs2_data  in  32  store data
- DM_req  out  1  memory request valid
- DM_we  out  4  byte write enables; 0 = read
- DM_addr  out  32  word address {M_aluOut[31:2],2'b00}
- DM_wdata  out  32  lane-replicated store data
- DM_ready  in  1  memory accepts request this cycle
- DM_rvalid  in  1  read data valid
- DM_rdata  in  32  read data word
- DM_stall  out  1  freeze pipeline registers
- M_ldData  out  32  formatted load result, valid in DONE
- M_misalign  out  1  misaligned/illegal access flag

Behaviour:
- Memory op: M_op==STORE_OP, or M_op==LOAD_OP with M_rd!=0.
  - Load to x0 is a NOP: no request, no stall. This also makes the all-zero reset bubble inert.
- Legal funct3:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other funct3 is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned or illegal: no DM_req, no stall, M_misalign=1 for that M cycle, M_ldData=0.
- FSM states IDLE, REQ, WAIT, DONE. Reset: IDLE; DM_req=0, DM_we=0, DM_addr=0, DM_wdata=0, DM_stall=0, M_ldData=0, M_misalign=0, load register=0.
- IDLE, valid memory op present:
  - DM_req=1 and DM_stall=1, combinationally in the same cycle.
  - On DM_ready: store -> DONE; load -> WAIT. Otherwise -> REQ.
- REQ: DM_req, DM_addr, DM_we and DM_wdata held stable; DM_stall=1. On DM_ready: store -> DONE, load -> WAIT.
- WAIT: DM_req=0, DM_stall=1. On DM_rvalid, capture the formatted load data into the load register and go to DONE.
  - DM_rvalid is never returned in the same cycle as DM_ready.
- DONE: DM_stall=0, M_ldData=load register.
  - IM_stall=1: stay in DONE, holding data; no re-issue.
  - IM_stall=0: -> IDLE. The pipeline advances on this same edge.
- DM_stall is never asserted in DONE, so DONE is not deadlocked by this unit.
- Minimum latency: store 2 cycles, load 3 cycles, from M entry to advance.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, we=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, we=addr[1]?4'b1100:4'b0011.
  - SW: wdata=rs2, we=4'b1111.
- Load formatting: select the byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- DM_we=0 whenever DM_req=0 or the op is a load.
- Rules while busy:
  - M inputs are stable (guaranteed by DM_stall); the FSM latches nothing from them except load data.
  - IM_stall in IDLE/REQ/WAIT does not block the memory transaction.
- Reset mid-transaction: FSM returns to IDLE immediately and all outputs go to reset values. The memory side discards the outstanding transaction on the same rst.

Test Plan:
- Reset bubble (all-zero M inputs) for 5 cycles -> DM_req=0, DM_stall=0, M_misalign=0 every cycle.
- SB: rs2=0x000000A5, addr=0x1003, DM_ready=1 immediately -> cycle0: DM_req=1, DM_addr=0x1000, DM_we=4'b1000, DM_wdata=0xA5A5A5A5, DM_stall=1; cycle1: DONE, DM_stall=0.
- LH: addr=0x2002, rd=5, DM_ready delayed 2 cycles, DM_rvalid 1 cycle later with rdata=0x80017F00 -> DM_req held 3 cycles with stable addr 0x2000; M_ldData=0xFFFF8001 in DONE; DM_stall high for 4 cycles.
- LBU: addr=0x10, rdata=0x000000F0; DONE coincides with IM_stall=1 for 3 cycles -> stays in DONE; M_ldData=0x000000F0 held; no second DM_req.
- LW: addr=0x6 -> M_misalign=1, DM_req=0, DM_stall=0. Load with rd=0 -> no request.
- Assert rst during WAIT -> next cycle: IDLE, DM_stall=0, M_ldData=0; a later rvalid is ignored.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the M-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  logic              DM_req;
  logic [NBYTES-1:0] DM_we;
  logic [XLEN-1:0]   DM_addr;
  logic [XLEN-1:0]   DM_wdata;
  logic              DM_ready;
  logic              DM_rvalid;
  logic [XLEN-1:0]   DM_rdata;

  modport master (
    output DM_req, DM_we, DM_addr, DM_wdata,
    input  DM_ready, DM_rvalid, DM_rdata
  );

  modport slave (
    input  DM_req, DM_we, DM_addr, DM_wdata,
    output DM_ready, DM_rvalid, DM_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one data-memory transaction per load/store, stalling the
// pipeline until it completes, and formatting load data for the MEM/WB register.
module mem_stage_lsu #(
  parameter logic [4:0] LOAD_OP  = 5'b00000,
  parameter logic [4:0] STORE_OP = 5'b01000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IM_stall,
  input  logic [4:0]           M_op,
  input  logic [2:0]           M_func3,
  input  logic [4:0]           M_rd,
  input  logic [31:0]          M_aluOut,
  input  logic [31:0]          M_rs2_data,
  mem_stage_lsu_if.master      dm,
  output logic                 DM_stall,
  output logic [31:0]          M_ldData,
  output logic                 M_misalign
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   ld_q, ld_d;

  logic              is_load, is_store, mem_op;
  logic              f3_legal, misaligned, bad_access, go;
  logic [1:0]        off;
  logic [NBYTES-1:0] st_we;
  logic [XLEN-1:0]   st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_fmt;

  logic              req_c, stall_c, misalign_c;
  logic [XLEN-1:0]   ld_out_c;

  // Decode; a load to x0 is treated as a NOP so the all-zero bubble is inert.
  always_comb begin
    off      = M_aluOut[1:0];
    is_load  = (M_op == LOAD_OP) && (M_rd != 5'd0);
    is_store = (M_op == STORE_OP);
    mem_op   = is_load || is_store;

    f3_legal = 1'b0;
    if (is_load) begin
      f3_legal = (M_func3 == 3'd0) || (M_func3 == 3'd1) || (M_func3 == 3'd2) ||
                 (M_func3 == 3'd4) || (M_func3 == 3'd5);
    end else if (is_store) begin
      f3_legal = (M_func3 == 3'd0) || (M_func3 == 3'd1) || (M_func3 == 3'd2);
    end

    misaligned = ((M_func3[1:0] == 2'd1) && off[0]) ||
                 ((M_func3[1:0] == 2'd2) && (off != 2'd0));
    bad_access = mem_op && (!f3_legal || misaligned);
    go         = mem_op && !bad_access;
  end

  // Store lane replication and byte enables.
  always_comb begin
    st_we    = '0;
    st_wdata = '0;
    case (M_func3[1:0])
      2'd0: begin
        st_wdata = {4{M_rs2_data[7:0]}};
        st_we    = NBYTES'(4'b0001 << off);
      end
      2'd1: begin
        st_wdata = {2{M_rs2_data[15:0]}};
        st_we    = off[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        st_wdata = M_rs2_data;
        st_we    = 4'b1111;
      end
      default: begin
        st_wdata = '0;
        st_we    = '0;
      end
    endcase
  end

  // Load lane select and extension.
  always_comb begin
    ld_byte = 8'd0;
    case (off)
      2'd0: ld_byte = dm.DM_rdata[7:0];
      2'd1: ld_byte = dm.DM_rdata[15:8];
      2'd2: ld_byte = dm.DM_rdata[23:16];
      2'd3: ld_byte = dm.DM_rdata[31:24];
      default: ld_byte = 8'd0;
    endcase
    ld_half = off[1] ? dm.DM_rdata[31:16] : dm.DM_rdata[15:0];

    ld_fmt = '0;
    case (M_func3)
      3'd0: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd1: ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd2: ld_fmt = dm.DM_rdata;
      3'd4: ld_fmt = {24'd0, ld_byte};
      3'd5: ld_fmt = {16'd0, ld_half};
      default: ld_fmt = '0;
    endcase
  end

  // Next-state and handshake outputs; DONE never stalls so the pipeline can advance.
  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    ld_out_c   = '0;

    case (state_q)
      S_IDLE: begin
        misalign_c = bad_access;
        if (go) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          if (dm.DM_ready) begin
            state_d = is_store ? S_DONE : S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dm.DM_ready) begin
          state_d = is_store ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (dm.DM_rvalid) begin
          ld_d    = ld_fmt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ld_out_c = ld_q;
        if (!IM_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
    end
  end

  // Outputs are forced to their reset values while rst is high.
  always_comb begin
    dm.DM_req    = req_c && !rst;
    dm.DM_addr   = dm.DM_req ? {M_aluOut[31:2], 2'b00} : '0;
    dm.DM_we     = (dm.DM_req && is_store) ? st_we : '0;
    dm.DM_wdata  = (dm.DM_req && is_store) ? st_wdata : '0;
    DM_stall     = stall_c && !rst;
    M_misalign   = misalign_c && !rst;
    M_ldData     = rst ? '0 : ld_out_c;
  end

endmodule
